run_ctrl: RTL
=============

Name: run_ctrl

Overview:
Run controller directly upstream of the CPU top level.
- Streams an input image into data memory over a valid/ready byte interface.
- Holds the CPU in reset during load, then releases it and waits for its done flag (or a watchdog timeout).
- Streams a result region of data memory back out over a valid/ready byte interface.
- Owns the data-memory port whenever the CPU is not running.

Parameters:
AW, 8, data-memory address width
LOAD_BASE, 0, first memory address written by the load phase
LOAD_LEN, 64, bytes loaded, 1..2**AW
DUMP_BASE, 64, first memory address read by the dump phase
DUMP_LEN, 64, bytes dumped, 1..2**AW
CW, 24, cycle counter width
MAX_CYCLES, 2**20, watchdog limit in RUN cycles, must be less than 2**CW

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a job when IDLE
in_valid  in  1  load byte valid
in_data  in  8  load byte
in_ready  out  1  load byte accepted when in_valid & in_ready
out_valid  out  1  dump byte valid
out_data  out  8  dump byte
out_ready  in  1  dump byte consumed when out_valid & out_ready
mem_sel  out  1  1 = controller drives data-memory port, 0 = CPU drives it
mem_wr_en  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, combinational from mem_addr
cpu_reset  out  1  reset to CPU core, active-high
cpu_done  in  1  CPU done flag, combinational from the CPU
busy  out  1  high in every state except IDLE and FIN
timeout  out  1  sticky; watchdog expired on the current job
cycle_count  out  CW  RUN cycles of the current job, saturating
finished  out  1  high in FIN

Behaviour:
- Reset values: state=IDLE, cpu_reset=1, mem_sel=1, mem_wr_en=0, in_ready=0, out_valid=0, out_data=0, timeout=0, cycle_count=0, finished=0, busy=0.
- Reset mid-operation aborts the job immediately: CPU held in reset, pending out byte dropped.
- States: IDLE, LOAD, RST, RUN, DUMP, FIN.
- IDLE:
  - cpu_reset=1, mem_sel=1.
  - start -> LOAD; clears idx, timeout and cycle_count.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - On each handshake, same cycle: mem_wr_en=1, mem_addr=LOAD_BASE+idx (mod 2**AW), mem_wdata=in_data; idx increments.
  - After handshake number LOAD_LEN -> RST; in_ready drops the next cycle.
  - Throughput is 1 byte/cycle; in_valid low stalls without side effects.
- RST:
  - cpu_reset=1 for exactly 2 cycles.
  - mem_sel goes to 0 on entry to RST.
  - Then -> RUN.
- RUN:
  - cpu_reset=0, mem_sel=0.
  - cycle_count increments every RUN cycle, saturating at 2**CW-1.
  - cpu_done is ignored in the first RUN cycle; from the second cycle, cpu_done=1 -> DUMP.
  - If cycle_count reaches MAX_CYCLES with no done: timeout=1 and -> DUMP.
  - If done and limit coincide, done wins and timeout stays 0.
- DUMP:
  - cpu_reset=1, mem_sel=1, idx restarts at 0.
  - mem_addr=DUMP_BASE+idx (mod 2**AW).
  - One-entry output register: loads mem_rdata and increments idx when empty, or when full and out_ready is high.
  - Allows 1 byte/cycle; first out_valid appears 1 cycle after DUMP entry.
  - out_data is stable while out_valid & !out_ready.
  - After the last byte's handshake -> FIN.
- FIN:
  - finished=1, cpu_reset=1.
  - cycle_count and timeout are held.
  - start -> LOAD for a new job; status is cleared.
- Address wrap past 2**AW-1 goes to 0; no error flagged.

Optional Feature:
- Macro: RUN_CTRL_CHECKSUM_EN.
- Defined: after the last dump byte, one extra byte is emitted, equal to the XOR of all DUMP_LEN dumped bytes, with the same handshake rules. FIN is entered after it is consumed.
- Undefined: the dump ends after DUMP_LEN bytes and no checksum logic exists.

Decomposition:
- Package run_ctrl_pkg:
  - state enum run_state_e (IDLE, LOAD, RST, RUN, DUMP, FIN)
  - RST_HOLD_CYCLES=2 constant
  - byte typedef
- Sub-module run_ctrl_obuf: one-entry valid/ready output register with load/accept logic, reused for the checksum byte.

Test Plan:
- Load 64 bytes 0x00..0x3F, continuous in_valid -> 64 writes to addresses 0..63 in consecutive cycles; in_ready low on cycle 65; cpu_reset low 2 cycles after the last write.
- cpu_done raised on the 10th RUN cycle -> cycle_count=10, timeout=0, state DUMP next cycle, CPU back in reset.
- cpu_done held low, MAX_CYCLES=100 -> timeout=1 at cycle_count=100; dump still emits DUMP_LEN bytes.
- Dump with out_ready toggling 1,0,0,1 and memory preset 0xA0..: bytes emitted in address order, no loss or duplication, out_data stable during stalls.
- reset asserted mid-LOAD after 5 bytes, then a new start -> idx restarts at LOAD_BASE, cpu_reset=1 throughout, timeout=0.
- With RUN_CTRL_CHECKSUM_EN, dump of 0x01,0x02,0x04 (DUMP_LEN=3) -> a fourth byte of 0x07, then finished=1.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RST,
      RUN,
      DUMP,
      FIN
   } run_state_e;

   localparam int RST_HOLD_CYCLES = 2;

   typedef logic [7:0] byte_t;

endpackage

// File: rtl/run_ctrl_obuf.sv
// One-entry valid/ready output register; the caller may load only when can_load is high.
module run_ctrl_obuf
   import run_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  byte_t load_data,
   input  logic  out_ready,
   output logic  out_valid,
   output byte_t out_data,
   output logic  can_load
);

   assign can_load = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: loads an image, runs the CPU under a watchdog, dumps the result region.
// Optional trailing XOR checksum byte on the dump when RUN_CTRL_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | CPU in reset, controller owns memory, waiting for start
// LOAD  | accepting input bytes into memory at LOAD_BASE
// RST   | CPU held in reset for RST_HOLD_CYCLES, CPU owns memory
// RUN   | CPU running; watchdog counting
// DUMP  | streaming DUMP_LEN bytes from DUMP_BASE out
// FIN   | job complete, status held until next start
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int AW         = 8,
   parameter int LOAD_BASE  = 0,
   parameter int LOAD_LEN   = 64,
   parameter int DUMP_BASE  = 64,
   parameter int DUMP_LEN   = 64,
   parameter int CW         = 24,
   parameter int MAX_CYCLES = 2**20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [7:0]    out_data,
   input  logic          out_ready,
   output logic          mem_sel,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic          cpu_reset,
   input  logic          cpu_done,
   output logic          busy,
   output logic          timeout,
   output logic [CW-1:0] cycle_count,
   output logic          finished
);

   localparam int IW = AW + 2;
`ifdef RUN_CTRL_CHECKSUM_EN
   localparam int DUMP_TOTAL = DUMP_LEN + 1;
`else
   localparam int DUMP_TOTAL = DUMP_LEN;
`endif
   localparam logic [IW-1:0] LOAD_LAST     = IW'(LOAD_LEN - 1);
   localparam logic [IW-1:0] DUMP_DATA_END = IW'(DUMP_LEN);
   localparam logic [IW-1:0] DUMP_END      = IW'(DUMP_TOTAL);
   localparam logic [AW-1:0] LOAD_BASE_A   = AW'(LOAD_BASE);
   localparam logic [AW-1:0] DUMP_BASE_A   = AW'(DUMP_BASE);
   localparam logic [CW-1:0] WD_LAST       = CW'(MAX_CYCLES - 1);
   localparam logic [1:0]    HOLD_INIT     = 2'(RST_HOLD_CYCLES - 1);

   run_state_e    state, state_nx;
   logic [IW-1:0] idx;
   logic [1:0]    hold_cnt;
   logic          wd_expire;
   logic          obuf_load;
   logic          obuf_can_load;
   byte_t         obuf_data;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_sel   = 1'b1;
      cpu_reset = 1'b1;
      busy      = 1'b1;
      finished  = 1'b0;
      wd_expire = 1'b0;
      obuf_load = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            mem_addr = LOAD_BASE_A + idx[AW-1:0];
            if (in_valid) begin
               mem_wr_en = 1'b1;
               mem_wdata = in_data;
               if (idx == LOAD_LAST) state_nx = RST;
            end
         end
         RST: begin
            mem_sel = 1'b0;
            if (hold_cnt == '0) state_nx = RUN;
         end
         RUN: begin
            mem_sel   = 1'b0;
            cpu_reset = 1'b0;
            // cycle_count is zero only in the first RUN cycle, where done is not trusted
            if (cpu_done && cycle_count != '0) begin
               state_nx = DUMP;
            end else if (cycle_count == WD_LAST) begin
               state_nx  = DUMP;
               wd_expire = 1'b1;
            end
         end
         DUMP: begin
            mem_addr  = DUMP_BASE_A + idx[AW-1:0];
            obuf_load = obuf_can_load && (idx != DUMP_END);
            if (out_valid && out_ready && idx == DUMP_END) state_nx = FIN;
         end
         FIN: begin
            busy     = 1'b0;
            finished = 1'b1;
            if (start) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx         <= '0;
         hold_cnt    <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  idx         <= '0;
                  cycle_count <= '0;
                  timeout     <= 1'b0;
               end
            end
            LOAD: begin
               hold_cnt <= HOLD_INIT;
               if (in_valid) idx <= idx + IW'(1);
            end
            RST: begin
               if (hold_cnt != '0) hold_cnt <= hold_cnt - 2'd1;
            end
            RUN: begin
               idx <= '0;
               if (cycle_count != '1) cycle_count <= cycle_count + CW'(1);
               if (wd_expire) timeout <= 1'b1;
            end
            DUMP: begin
               if (obuf_load) idx <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef RUN_CTRL_CHECKSUM_EN
   byte_t csum;

   always_ff @(posedge clk) begin
      if (reset)                                csum <= '0;
      else if (state == RUN)                    csum <= '0;
      else if (obuf_load && idx != DUMP_DATA_END) csum <= csum ^ mem_rdata;
   end

   assign obuf_data = (idx == DUMP_DATA_END) ? csum : mem_rdata;
`else
   assign obuf_data = mem_rdata;
`endif

   run_ctrl_obuf u_obuf (
      .clk       (clk),
      .reset     (reset),
      .load      (obuf_load),
      .load_data (obuf_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .can_load  (obuf_can_load)
   );

endmodule
